// File: rtl/convert_fixed_to_float_v_pkg.sv
// Shared constants, FSM states and float field layout for the fixed<->float converters.
package convert_fixed_to_float_v_pkg;

    localparam int W      = 32;   // fixed-point and float word width
    localparam int FRAC   = 30;   // fraction bits of the fixed format
    localparam int BIAS   = 127;  // single-precision exponent bias
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int POS_W  = 5;    // width of a bit position inside a W-bit word

    // Float field slice indices: {sign, exp[7:0], mant[22:0]}
    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_HI  = 22;
    localparam int MANT_LO  = 0;

    // Exponent of a value whose leading one sits at bit p is BIAS + p - FRAC.
    localparam int EXP_OFFSET = BIAS - FRAC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_LZC,
        ST_NORM,
        ST_PACK
    } state_e;

    // Assemble a float word from its three fields.
    function automatic logic [W-1:0] pack_float(input logic              sign,
                                                 input logic [EXP_W-1:0]  exp,
                                                 input logic [MANT_W-1:0] mant);
        logic [W-1:0] f;
        f                   = '0;
        f[SIGN_BIT]         = sign;
        f[EXP_HI:EXP_LO]    = exp;
        f[MANT_HI:MANT_LO]  = mant;
        return f;
    endfunction

endpackage

// File: rtl/convert_fixed_to_float_v_lzc.sv
// Combinational leading-one position encoder for a 32-bit word.
module LZC_32
    import convert_fixed_to_float_v_pkg::*;
(
    input  logic [W-1:0]     data,
    output logic [POS_W-1:0] p,
    output logic             zero
);

    // Scan upward so the highest set bit wins; p is 0 when data is zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        p    = '0;
        zero = (data == '0);
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                p = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/convert_fixed_to_float_v.sv
// Four-stage signed fixed-point (Q1.30) to IEEE-754 single-precision converter.
module convert_fixed_to_float_v
    import convert_fixed_to_float_v_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] FIXED,
    output logic         BUSY,
    output logic         READY,
    output logic [W-1:0] FLOAT
);

    state_e state_q, state_d;

    // Stage registers
    logic [W-1:0]      fixed_q;
    logic              sign_q;
    logic [W-1:0]      mag_q;
    logic [POS_W-1:0]  p_q;
    logic              zero_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_q;
    logic              g_q;
    logic              s_q;

    // Combinational helpers
    logic [POS_W-1:0]  lzc_p;
    logic              lzc_zero;
    logic [W-2:0]      norm_frac;   // bits below the leading one after normalisation
    logic              round_up;
    logic [MANT_W:0]   mant_sum;    // carry bit flags a mantissa overflow
    logic [EXP_W-1:0]  exp_rnd;

    LZC_32 u_lzc (
        .data (mag_q),
        .p    (lzc_p),
        .zero (lzc_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and BUSY decode; the pipeline walks one stage per cycle.
    always_comb begin
        state_d = state_q;
        BUSY    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (START) state_d = ST_ABS;
            ST_ABS:  state_d = ST_LZC;
            ST_LZC:  state_d = ST_NORM;
            ST_NORM: state_d = ST_PACK;
            ST_PACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Normalisation shift and round-to-nearest-even arithmetic.
    always_comb begin
        norm_frac = (W-1)'(mag_q << (POS_W'(W-1) - p_q));
        round_up  = g_q & (s_q | mant_q[0]);
        mant_sum  = {1'b0, mant_q} + (MANT_W+1)'(round_up);
        exp_rnd   = exp_q + EXP_W'(mant_sum[MANT_W]);
    end

    // Datapath: each stage register loads only while the FSM is in its state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fixed_q <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            p_q     <= '0;
            zero_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            FLOAT   <= '0;
            READY   <= 1'b0;
        end else begin
            READY <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) fixed_q <= FIXED;
                end
                ST_ABS: begin
                    // -2^31 negates to itself, which read unsigned is the correct magnitude.
                    sign_q <= fixed_q[W-1];
                    mag_q  <= fixed_q[W-1] ? -fixed_q : fixed_q;
                end
                ST_LZC: begin
                    p_q    <= lzc_p;
                    zero_q <= lzc_zero;
                end
                ST_NORM: begin
                    exp_q  <= EXP_W'(EXP_OFFSET) + EXP_W'(p_q);
                    mant_q <= norm_frac[W-2 -: MANT_W];
                    g_q    <= norm_frac[W-2-MANT_W];
                    s_q    <= |norm_frac[W-3-MANT_W:0];
                end
                ST_PACK: begin
                    // Zero always packs as +0; a mantissa carry has already bumped the exponent.
                    FLOAT <= zero_q ? '0 : pack_float(sign_q, exp_rnd, mant_sum[MANT_W-1:0]);
                    READY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convert_fixed_to_float_v.sv
// Self-checking bench for convert_fixed_to_float_v: vector table, corner sequences, random regression.
module tb_convert_fixed_to_float_v;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] FIXED;
    logic        BUSY;
    logic        READY;
    logic [31:0] FLOAT;

    convert_fixed_to_float_v dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .FIXED (FIXED),
        .BUSY  (BUSY),
        .READY (READY),
        .FLOAT (FLOAT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] fixed;
        logic [31:0] exp_float;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] sb[$];            // expected FLOAT per accepted conversion
    int          ready_cycles[$];  // cycle index of every READY pulse
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_ready  = 0;
    int          cycle    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // Reference: exact integer magnitude, rounded to 24 significant bits, ties to even.
    function automatic logic [31:0] ref_float(input logic [31:0] fx);
        longint      v;
        logic [63:0] m, q, rem, half;
        int          e, sh;
        logic        s;
        if (fx == 32'h0) return 32'h0;
        s = fx[31];
        v = longint'($signed(fx));
        if (v < 0) v = -v;
        m = 64'(v);
        e = 63;
        while (m[e] == 1'b0) e--;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh   = e - 23;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                e++;
            end
        end
        return {s, 8'(e + 127 - 30), q[22:0]};
    endfunction

    // Monitor: every READY pops the scoreboard and compares FLOAT.
    always @(posedge CLK) begin
        logic [31:0] want;
        #1;
        cycle++;
        if (READY === 1'b1) begin
            n_ready++;
            ready_cycles.push_back(cycle);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ready: READY with no pending conversion, FLOAT 0x%08h", FLOAT);
            end else begin
                want = sb.pop_front();
                check("float", FLOAT, want);
            end
        end
    end

    // Wait (bounded) for the next READY; called from a negedge.
    task automatic wait_ready(input string name);
        int start_cnt = n_ready;
        int waited    = 0;
        while (n_ready == start_cnt && waited < 12) begin
            @(negedge CLK);
            waited++;
        end
        check(name, 32'(n_ready - start_cnt), 32'd1);
    endtask

    // One conversion from IDLE; FIXED is scrambled right after acceptance.
    task automatic run_one(input logic [31:0] fx, input logic [31:0] exp_f);
        START = 1'b1;
        FIXED = fx;
        sb.push_back(exp_f);
        @(negedge CLK);
        START = 1'b0;
        FIXED = $urandom;
        wait_ready("ready_timeout");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          r0;
        logic [31:0] held_ops[3];
        logic [31:0] v;
        int          sh;

        vecs[0] = '{32'h40000000, 32'h3F800000};
        vecs[1] = '{32'hC0000000, 32'hBF800000};
        vecs[2] = '{32'h80000000, 32'hC0000000};
        vecs[3] = '{32'h20000000, 32'h3F000000};
        vecs[4] = '{32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00000001, 32'h30800000};
        vecs[6] = '{32'h7FFFFFFF, 32'h40000000};
        vecs[7] = '{32'h40000040, 32'h3F800000};
        vecs[8] = '{32'h400000C0, 32'h3F800002};

        RST   = 1'b1;
        START = 1'b0;
        FIXED = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset_busy",  32'(BUSY),  32'd0);
        check("reset_ready", 32'(READY), 32'd0);
        check("reset_float", FLOAT,      32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Exact latency: BUSY for four cycles, READY one cycle after edge n+4.
        START = 1'b1;
        FIXED = 32'h40000000;
        sb.push_back(32'h3F800000);
        @(posedge CLK);
        #1;
        START = 1'b0;
        FIXED = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check("lat_busy_high", 32'(BUSY),  32'd1);
            check("lat_ready_low", 32'(READY), 32'd0);
            @(posedge CLK);
            #1;
        end
        check("lat_ready_high", 32'(READY), 32'd1);
        check("lat_busy_low",   32'(BUSY),  32'd0);
        check("lat_float",      FLOAT,      32'h3F800000);
        @(posedge CLK);
        #1;
        check("lat_ready_pulse", 32'(READY), 32'd0);
        @(negedge CLK);

        // Vector table.
        foreach (vecs[i]) run_one(vecs[i].fixed, vecs[i].exp_float);

        // START pulsed while busy is ignored.
        r0    = n_ready;
        START = 1'b1;
        FIXED = 32'h20000000;
        sb.push_back(32'h3F000000);
        @(negedge CLK);
        FIXED = 32'hC0000000;
        repeat (2) @(negedge CLK);
        START = 1'b0;
        repeat (12) @(negedge CLK);
        check("busy_start_ignored", 32'(n_ready - r0), 32'd1);

        // START held high: a new operand is captured every five cycles.
        held_ops[0] = 32'h7FFFFFFF;
        held_ops[1] = 32'h80000000;
        held_ops[2] = 32'h400000C0;
        ready_cycles.delete();
        r0    = n_ready;
        START = 1'b1;
        for (int k = 0; k < 3; k++) begin
            FIXED = held_ops[k];
            sb.push_back(ref_float(held_ops[k]));
            @(negedge CLK);
            FIXED = $urandom;
            repeat (4) @(negedge CLK);
        end
        START = 1'b0;
        repeat (8) @(negedge CLK);
        check("held_ready_count", 32'(n_ready - r0), 32'd3);
        if (ready_cycles.size() == 3) begin
            check("held_gap0", 32'(ready_cycles[1] - ready_cycles[0]), 32'd5);
            check("held_gap1", 32'(ready_cycles[2] - ready_cycles[1]), 32'd5);
        end

        // Reset while in NORM discards the conversion.
        r0    = n_ready;
        START = 1'b1;
        FIXED = 32'h12345678;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_norm_busy",  32'(BUSY),  32'd0);
        check("rst_norm_float", FLOAT,      32'h0);
        check("rst_norm_ready", 32'(READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        check("rst_norm_no_ready", 32'(n_ready - r0), 32'd0);
        run_one(32'hC0000000, 32'hBF800000);

        // Random regression across all magnitudes and both signs.
        for (int i = 0; i < 1500; i++) begin
            sh = $urandom_range(0, 31);
            v  = $urandom >> sh;
            if ($urandom_range(0, 1) == 1) v = -v;
            run_one(v, ref_float(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
